// File: rtl/amba3_apb_arbiter_if.sv
// Requester-side and APB-side signal bundle for amba3_apb_arbiter.
// Latency: n/a (wires only). Backpressure: requesters hold req until done; APB side stalls on pready.
// Ports: req/req_addr/req_write/req_wdata in, done/rsp_* out (requester side);
//        psel/penable/pwrite/paddr/pwdata out, prdata/pready/pslverr in (APB side).
interface amba3_apb_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // requester side
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
    logic [NUM_REQ-1:0]           req_write;
    logic [NUM_REQ*DATA_BITS-1:0] req_wdata;
    logic [NUM_REQ-1:0]           done;
    logic [IW-1:0]                rsp_id;
    logic [DATA_BITS-1:0]         rsp_rdata;
    logic                         rsp_slverr;
    logic                         rsp_timeout;
    logic                         busy;

    // APB side
    logic                         psel;
    logic                         penable;
    logic                         pwrite;
    logic [ADDR_BITS-1:0]         paddr;
    logic [DATA_BITS-1:0]         pwdata;
    logic [DATA_BITS-1:0]         prdata;
    logic                         pready;
    logic                         pslverr;

    // arbiter view
    modport master (
        input  req, req_addr, req_write, req_wdata, prdata, pready, pslverr,
        output done, rsp_id, rsp_rdata, rsp_slverr, rsp_timeout, busy,
        output psel, penable, pwrite, paddr, pwdata
    );

    // requesters + APB slave view
    modport slave (
        output req, req_addr, req_write, req_wdata, prdata, pready, pslverr,
        input  done, rsp_id, rsp_rdata, rsp_slverr, rsp_timeout, busy,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/amba3_apb_arbiter.sv
// Round-robin arbiter sharing one AMBA 3 APB master port between NUM_REQ requesters.
// Latency: grant sampled in IDLE, SETUP next cycle, done pulse 3 cycles after grant plus APB wait states.
// Backpressure: requesters hold req until done; slave stalls with pready, optional TIMEOUT abort.
// Ports: pclk (clock), preset (async active-high reset), bus (amba3_apb_arbiter_if.master).
module amba3_apb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int TIMEOUT   = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    amba3_apb_arbiter_if.master   bus
);
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t                 r_state;
    logic [IW-1:0]          r_rr_ptr;
    logic [CW-1:0]          r_wait;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [ADDR_BITS-1:0]   r_paddr;
    logic [DATA_BITS-1:0]   r_pwdata;
    logic [NUM_REQ-1:0]     r_done;
    logic [IW-1:0]          r_rsp_id;
    logic [DATA_BITS-1:0]   r_rsp_rdata;
    logic                   r_rsp_slverr;
    logic                   r_rsp_timeout;
    logic                   r_busy;

    logic                   w_gnt_vld;
    logic [IW-1:0]          w_gnt_idx;
    logic [IW-1:0]          w_cand;
    logic                   w_to_hit;
    logic                   w_acc_end;

    // Walk candidates from the farthest offset back to rr_ptr itself, so the
    // last hit (closest to rr_ptr in wrap order) wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (bus.req[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    // Counter holds the index of the current ACCESS cycle; the abort fires
    // on the TIMEOUT-th ACCESS cycle if the slave is still not ready.
    assign w_to_hit  = (TIMEOUT > 0) && (r_wait == CW'(TO_LAST));
    assign w_acc_end = bus.pready || w_to_hit;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_wait        <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_done        <= '0;
            r_rsp_id      <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_state  <= S_SETUP;
                        r_busy   <= 1'b1;
                        r_psel   <= 1'b1;
                        r_rsp_id <= w_gnt_idx;
                        r_paddr  <= bus.req_addr[w_gnt_idx*ADDR_BITS +: ADDR_BITS];
                        r_pwdata <= bus.req_wdata[w_gnt_idx*DATA_BITS +: DATA_BITS];
                        r_pwrite <= bus.req_write[w_gnt_idx];
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                end
                S_ACCESS: begin
                    r_wait <= r_wait + CW'(1);
                    if (w_acc_end) begin
                        r_state            <= S_DONE;
                        r_psel             <= 1'b0;
                        r_penable          <= 1'b0;
                        r_done[r_rsp_id]   <= 1'b1;
                        // pready has priority: a response on the last allowed cycle is not a timeout
                        r_rsp_timeout      <= !bus.pready;
                        r_rsp_slverr       <= bus.pready ? bus.pslverr : 1'b1;
                        r_rsp_rdata        <= (bus.pready && !r_pwrite) ? bus.prdata : '0;
                    end
                end
                S_DONE: begin
                    // req is deliberately not looked at here
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_done   <= '0;
                    r_rr_ptr <= (int'(r_rsp_id) == NUM_REQ - 1) ? '0 : r_rsp_id + IW'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.pwrite      = r_pwrite;
    assign bus.paddr       = r_paddr;
    assign bus.pwdata      = r_pwdata;
    assign bus.done        = r_done;
    assign bus.rsp_id      = r_rsp_id;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_slverr  = r_rsp_slverr;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.busy        = r_busy;
endmodule

// File: doc/amba3_apb_arbiter.md
# amba3_apb_arbiter

Round-robin arbiter that shares one AMBA 3 APB master port between `NUM_REQ` requesters, each using a simple request/done handshake. The arbiter latches the winner's address, direction and write data, then runs the APB SETUP/ACCESS sequence. It returns `prdata`/`pslverr` with a one-cycle done pulse. It sits between on-chip command sources (test sequencers, register-access engines) and the APB interconnect in front of `amba3_apb_if` slaves, and adds an optional ACCESS-phase timeout.

## Interface
- `NUM_REQ`, 4, number of requesters (≥1); `IW = max(1, $clog2(NUM_REQ))`
- `ADDR_BITS`, 32, APB address width
- `DATA_BITS`, 32, APB data width
- `TIMEOUT`, 0, max ACCESS cycles without `pready` before abort; 0 disables the timeout
- `pclk`  in  1  clock; all state updates on the rising edge
- `preset`  in  1  reset, asynchronous, active-high
- `req`  in  NUM_REQ  per-requester request level
- `req_addr`  in  NUM_REQ*ADDR_BITS  packed addresses; requester i uses slice [i*ADDR_BITS +: ADDR_BITS]
- `req_write`  in  NUM_REQ  1 = write, 0 = read
- `req_wdata`  in  NUM_REQ*DATA_BITS  packed write data
- `done`  out  NUM_REQ  one-hot, one-cycle completion pulse
- `rsp_id`  out  IW  index of the requester being served or just completed
- `rsp_rdata`  out  DATA_BITS  captured `prdata` (reads) or 0 (writes and timeouts)
- `rsp_slverr`  out  1  captured `pslverr`, or 1 on timeout
- `rsp_timeout`  out  1  completion was a timeout abort
- `busy`  out  1  state ≠ IDLE
- `psel`, `penable`, `pwrite`  out  1  APB control
- `paddr`  out  ADDR_BITS  APB address
- `pwdata`  out  DATA_BITS  APB write data
- `prdata`  in  DATA_BITS  APB read data
- `pready`, `pslverr`  in  1  APB response

## Operation
- **Requester handshake:** requester i raises `req[i]` with its addr/write/wdata fields, and holds all of them stable until it samples `done[i]`=1. It may then drop `req[i]`, or present the next transfer with new fields on the following cycle.
- **FSM states:** IDLE, SETUP, ACCESS, DONE.
- **IDLE:**
  - If any `req` bit is set, pick the winner round-robin, searching from index `rr_ptr`.
  - Latch the winner's addr, write and wdata into `paddr`/`pwrite`/`pwdata`; set `rsp_id`; go to SETUP.
  - With no requests, stay in IDLE.
- **SETUP:** `psel`=1, `penable`=0; always go to ACCESS next.
- **ACCESS:** `psel`=1, `penable`=1; wait-state counter increments every cycle in this state.
  - `pready`=1: capture `prdata` (reads only; writes give 0) and `pslverr`; `rsp_timeout`=0; go to DONE.
  - `TIMEOUT`>0 and counter reaches `TIMEOUT`-1 with `pready`=0: abort. Set `rsp_rdata`=0, `rsp_slverr`=1, `rsp_timeout`=1; go to DONE.
- **DONE:** `psel`=`penable`=0; `done[rsp_id]`=1 for exactly this cycle; `rr_ptr` ← (`rsp_id`+1) mod `NUM_REQ`; go to IDLE.
  - `req` is ignored in DONE, so a requester that has not yet seen its done pulse is never re-granted early.
- `paddr`, `pwrite` and `pwdata` hold their latched values from SETUP through DONE. Later changes on `req_*` do not affect an in-flight transfer.
- `rsp_rdata`, `rsp_slverr` and `rsp_timeout` hold until the next completion.
- Dropping `req[i]` while it is being served does not cancel the transfer; it still completes and pulses `done[i]`.

## Timing
- **Reset values:**
  - FSM = IDLE, `rr_ptr`=0, wait counter = 0.
  - `psel`=`penable`=`pwrite`=0; `paddr`=0, `pwdata`=0.
  - `done`=0, `rsp_id`=0, `rsp_rdata`=0, `rsp_slverr`=0, `rsp_timeout`=0, `busy`=0.
- **Latency:**
  - `req` sampled in IDLE at edge E0.
  - SETUP from E0+1, ACCESS from E0+2.
  - With zero wait states, `done` is high in cycle E0+3 and the arbiter is back in IDLE at E0+4.
  - Each wait state adds one cycle.
- **Throughput:** with every requester continuously requesting, one transfer per 4 cycles at zero wait states.
- **Round-robin:** at the IDLE decision, the winner is the lowest index ≥ `rr_ptr` with `req` set, wrapping to 0. After N−1 wraps to 0.
- **Timeout example:** with `TIMEOUT`=T, the abort occurs at the end of the T-th ACCESS cycle.
- **Reset mid-transfer:** `psel`/`penable` drop immediately (asynchronously) and no `done` is issued. The requester must re-request after reset.

## Test plan
- **Single write:**
  - Stimulus: `req[2]`=1, addr 'h0040, wdata 'h80003333, write; slave `pready`=1 at once.
  - Required: `psel` then `penable` one cycle apart with `paddr`='h0040, `pwdata`='h80003333; `done`=4'b0100 exactly 3 cycles after the IDLE sample; `rsp_id`=2.
- **Read with wait states:**
  - Stimulus: read 'h0140; slave holds `pready`=0 for 3 cycles, then returns `prdata`='h0000001C.
  - Required: ACCESS lasts 4 cycles; `rsp_rdata`='h0000001C; `rsp_slverr`=0.
- **Fairness:**
  - Stimulus: all four `req` held high for 8 transfers.
  - Required: grant order 0,1,2,3,0,1,2,3; each transfer is 4 cycles.
- **Timeout:**
  - Stimulus: `TIMEOUT`=8, slave never asserts `pready`.
  - Required: abort after 8 ACCESS cycles; `rsp_slverr`=1, `rsp_timeout`=1, `rsp_rdata`=0; `psel` low in DONE.
- **Error and stability:**
  - Stimulus: slave returns `pslverr`=1 on a write; the requester changes `req_addr` during ACCESS.
  - Required: `rsp_slverr`=1; `paddr` unchanged until DONE.
- **Reset mid-ACCESS:**
  - Stimulus: `preset` asserted during ACCESS.
  - Required: `psel`/`penable`/`done` go to 0 without waiting for a clock edge; after release, the first grant starts from `rr_ptr`=0.
